// File: rtl/floating_point_multiplier_seq.sv
// floating_point_multiplier_seq: iterative IEEE-754 multiplier, radix-2 shift-add mantissa product, RNE rounding
module floating_point_multiplier_seq #(
    parameter int WIDTH = 32,
    parameter int EXP_WIDTH = 8,
    parameter int MANT_WIDTH = 23
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_invalid,
    output logic             flag_overflow,
    output logic             flag_underflow
);
    localparam int MW = MANT_WIDTH + 1;
    localparam int PW = 2 * MW;
    localparam int XW = EXP_WIDTH + 2;
    localparam int CW = $clog2(MW);
    localparam int BIAS = 2 ** (EXP_WIDTH - 1) - 1;
    localparam logic signed [XW-1:0] E_BIAS = XW'(BIAS);
    localparam logic signed [XW-1:0] E_MAX = XW'(2 ** EXP_WIDTH - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MW - 1);
    localparam logic [WIDTH-1:0] QNAN = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t state_q, state_d;
    logic sign_q, sign_d;
    logic [EXP_WIDTH-1:0] ea_q, ea_d, eb_q, eb_d;
    logic [MW-1:0] ma_q, ma_d, mb_q, mb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] acc_q, acc_d;
    logic spec_q, spec_d, spec_inv_q, spec_inv_d;
    logic [WIDTH-1:0] spec_res_q, spec_res_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic inv_q, inv_d, ovf_q, ovf_d, unf_q, unf_d;
    logic out_valid_q, out_valid_d;

    logic [EXP_WIDTH-1:0] ea_in, eb_in;
    logic [MANT_WIDTH-1:0] fa_in, fb_in;
    logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic sign_in, special_in, invalid_in;
    logic [WIDTH-1:0] spec_in;

    assign ea_in = a[WIDTH-2 -: EXP_WIDTH];
    assign eb_in = b[WIDTH-2 -: EXP_WIDTH];
    assign fa_in = a[MANT_WIDTH-1:0];
    assign fb_in = b[MANT_WIDTH-1:0];
    assign a_zero = ea_in == '0;
    assign b_zero = eb_in == '0;
    assign a_inf = &ea_in && fa_in == '0;
    assign b_inf = &eb_in && fb_in == '0;
    assign a_nan = &ea_in && fa_in != '0;
    assign b_nan = &eb_in && fb_in != '0;
    assign sign_in = a[WIDTH-1] ^ b[WIDTH-1];
    assign invalid_in = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
    assign special_in = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;
    assign spec_in = invalid_in ? QNAN :
                     (a_inf | b_inf) ? {sign_in, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}} :
                     {sign_in, {(WIDTH-1){1'b0}}};

    // Normalisation: a product below 2.0 is shifted up one place so the fraction always sits at the same bits.
    logic [PW-1:0] norm, addend;
    logic [MANT_WIDTH-1:0] mant;
    logic guard, sticky, ovf, unf;
    logic [MANT_WIDTH:0] rnd;
    logic signed [XW-1:0] e_base, e_fin;

    assign addend = mb_q[cnt_q] ? PW'(ma_q) << cnt_q : '0;
    assign norm = acc_q[PW-1] ? acc_q : acc_q << 1;
    assign mant = norm[PW-2 -: MANT_WIDTH];
    assign guard = norm[PW-2-MANT_WIDTH];
    assign sticky = |norm[PW-3-MANT_WIDTH:0];
    assign rnd = {1'b0, mant} + (MANT_WIDTH+1)'(guard & (sticky | mant[0]));
    assign e_base = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - E_BIAS;
    assign e_fin = e_base + $signed(XW'(acc_q[PW-1]) + XW'(rnd[MANT_WIDTH]));
    assign ovf = e_fin >= E_MAX;
    assign unf = e_fin[XW-1] || e_fin == '0;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sign_q <= 1'b0;
            ea_q <= '0;
            eb_q <= '0;
            ma_q <= '0;
            mb_q <= '0;
            cnt_q <= '0;
            acc_q <= '0;
            spec_q <= 1'b0;
            spec_inv_q <= 1'b0;
            spec_res_q <= '0;
            result_q <= '0;
            inv_q <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q <= sign_d;
            ea_q <= ea_d;
            eb_q <= eb_d;
            ma_q <= ma_d;
            mb_q <= mb_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            spec_q <= spec_d;
            spec_inv_q <= spec_inv_d;
            spec_res_q <= spec_res_d;
            result_q <= result_d;
            inv_q <= inv_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next state: accept, shift-add one multiplier bit per cycle, round once, hold the result until taken.
    always_comb begin
        state_d = state_q;
        sign_d = sign_q;
        ea_d = ea_q;
        eb_d = eb_q;
        ma_d = ma_q;
        mb_d = mb_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        spec_d = spec_q;
        spec_inv_d = spec_inv_q;
        spec_res_d = spec_res_q;
        result_d = result_q;
        inv_d = inv_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: if (in_valid) begin
                sign_d = sign_in;
                ea_d = ea_in;
                eb_d = eb_in;
                ma_d = {1'b1, fa_in};
                mb_d = {1'b1, fb_in};
                cnt_d = '0;
                acc_d = '0;
                spec_d = special_in;
                spec_inv_d = invalid_in;
                spec_res_d = spec_in;
                state_d = special_in ? NORM : MUL;
            end
            MUL: begin
                acc_d = acc_q + addend;
                cnt_d = cnt_q + 1'b1;
                state_d = cnt_q == CNT_LAST ? NORM : MUL;
            end
            NORM: begin
                result_d = spec_q ? spec_res_q :
                           ovf ? {sign_q, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}} :
                           unf ? {sign_q, {(WIDTH-1){1'b0}}} :
                           {sign_q, e_fin[EXP_WIDTH-1:0], rnd[MANT_WIDTH-1:0]};
                inv_d = spec_q & spec_inv_q;
                ovf_d = !spec_q & ovf;
                unf_d = !spec_q & !ovf & unf;
                state_d = DONE;
            end
            default: begin
                out_valid_d = 1'b1;
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    inv_d = 1'b0;
                    ovf_d = 1'b0;
                    unf_d = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign in_ready = state_q == IDLE;
    assign out_valid = out_valid_q;
    assign result = result_q;
    assign flag_invalid = inv_q;
    assign flag_overflow = ovf_q;
    assign flag_underflow = unf_q;
endmodule

// File: tb/tb_floating_point_multiplier_seq.sv
// tb_floating_point_multiplier_seq: random and directed operands checked against an arithmetic reference model
module tb_floating_point_multiplier_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic [31:0] result;
    logic flag_invalid, flag_overflow, flag_underflow;

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    bit started = 0;
    bit hold = 0;

    typedef struct {
        logic [31:0] res;
        logic [2:0] flags;
        int lat;
        int t0;
        bit seen;
    } exp_t;
    exp_t exp_q[$];

    floating_point_multiplier_seq dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_invalid(flag_invalid), .flag_overflow(flag_overflow), .flag_underflow(flag_underflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=%h want=%h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference: exact integer product, rounded to nearest-even by remainder comparison.
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [2:0] f, output int lat);
        logic s;
        int ex, ey, e, sh;
        longint unsigned p, q, rem, half;
        bit xz, xi, xn, yz, yi, yn;
        s = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        xz = ex == 0;
        yz = ey == 0;
        xi = ex == 255 && x[22:0] == 0;
        yi = ey == 255 && y[22:0] == 0;
        xn = ex == 255 && x[22:0] != 0;
        yn = ey == 255 && y[22:0] != 0;
        f = 3'b000;
        lat = 2;
        r = '0;
        if (xn || yn || (xi && yz) || (xz && yi)) begin
            r = 32'h7FC00000;
            f = 3'b100;
        end else if (xi || yi) begin
            r = {s, 8'hFF, 23'h0};
        end else if (xz || yz) begin
            r = {s, 31'h0};
        end else begin
            lat = 26;
            p = {40'h0, 1'b1, x[22:0]} * {40'h0, 1'b1, y[22:0]};
            e = ex + ey - 127;
            sh = 23;
            if (p >= (64'd1 << 47)) begin
                sh = 24;
                e++;
            end
            q = p >> sh;
            rem = p - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
            if (q == (64'd1 << 24)) begin
                q = q >> 1;
                e++;
            end
            if (e >= 255) begin
                r = {s, 8'hFF, 23'h0};
                f = 3'b010;
            end else if (e <= 0) begin
                r = {s, 31'h0};
                f = 3'b001;
            end else begin
                r = {s, e[7:0], q[22:0]};
            end
        end
    endfunction

    function automatic logic [31:0] rand_op();
        int c;
        logic [7:0] e;
        logic [22:0] fr;
        c = $urandom_range(0, 11);
        fr = 23'($urandom);
        e = c == 0 ? 8'd0 : (c == 1 || c == 2) ? 8'hFF : c == 3 ? 8'($urandom_range(1, 20)) :
            c == 4 ? 8'($urandom_range(230, 254)) : 8'($urandom_range(100, 154));
        if (c == 1) fr = '0;
        return {1'($urandom), e, fr};
    endfunction

    task automatic send(input logic [31:0] x, input logic [31:0] y);
        exp_t t;
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            in_valid = !out_valid && ($urandom_range(0, 1) == 1);
            a = $urandom;
            b = $urandom;
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            checks++;
            fails++;
            $display("FAIL send_timeout in_ready=%b want=1", in_ready);
            in_valid = 1'b0;
            return;
        end
        in_valid = 1'b1;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        model(x, y, t.res, t.flags, t.lat);
        t.t0 = cyc;
        t.seen = 0;
        exp_q.push_back(t);
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    // Compare process: every cycle, handshake state and any valid result against the queued expectation.
    always @(negedge clk) begin
        if (started && !reset) begin
            chk("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
            if (exp_q.size() > 0) begin
                if (out_valid) begin
                    if (!exp_q[0].seen) begin
                        chk("latency", cyc - exp_q[0].t0, exp_q[0].lat);
                        exp_q[0].seen = 1;
                    end
                    chk("result", result, exp_q[0].res);
                    chk("flags", 32'({flag_invalid, flag_overflow, flag_underflow}), 32'(exp_q[0].flags));
                    out_ready = !hold && $urandom_range(0, 2) != 0;
                    if (out_ready) void'(exp_q.pop_front());
                end else begin
                    out_ready = 1'b0;
                    if (cyc - exp_q[0].t0 > 40) begin
                        chk("out_valid_timeout", 32'(out_valid), 32'd1);
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                chk("spurious_out_valid", 32'(out_valid), 32'd0);
                out_ready = 1'b0;
            end
        end
    end

    logic [31:0] ta [9] = '{32'h40000000, 32'h3FC00000, 32'hC0000000, 32'h3F800001, 32'h3FFFFFFF,
                            32'h7F800000, 32'h7F7FFFFF, 32'h00800000, 32'h80000000};
    logic [31:0] tb [9] = '{32'h40400000, 32'h3FC00000, 32'h40400000, 32'h3F800001, 32'h3FFFFFFF,
                            32'h00000000, 32'h40000000, 32'h00800000, 32'h40000000};
    logic [31:0] tr [9] = '{32'h40C00000, 32'h40100000, 32'hC0C00000, 32'h3F800002, 32'h407FFFFE,
                            32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h80000000};
    logic [2:0] tf [9] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b010, 3'b001, 3'b000};

    initial begin
        logic [31:0] mr;
        logic [2:0] mf;
        int ml, w;
        bit seen;
        #12;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", result, 32'h0);
        chk("reset_flags", 32'({flag_invalid, flag_overflow, flag_underflow}), 32'd0);
        for (int i = 0; i < 9; i++) begin
            model(ta[i], tb[i], mr, mf, ml);
            chk($sformatf("model_res_%0d", i), mr, tr[i]);
            chk($sformatf("model_flags_%0d", i), 32'(mf), 32'(tf[i]));
        end
        @(negedge clk);
        reset = 1'b0;
        started = 1;
        for (int i = 0; i < 9; i++) send(ta[i], tb[i]);
        for (int i = 0; i < 300; i++) send(rand_op(), rand_op());
        w = 0;
        while (exp_q.size() > 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        hold = 1;
        send(32'h40000000, 32'h40400000);
        w = 0;
        while (!out_valid && w < 60) begin
            @(negedge clk);
            w++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_result", result, 32'h40C00000);
        end
        #2 reset = 1'b1;
        #1;
        exp_q.delete();
        chk("rst_done_out_valid", 32'(out_valid), 32'd0);
        chk("rst_done_in_ready", 32'(in_ready), 32'd1);
        chk("rst_done_result", result, 32'h0);
        @(negedge clk);
        #2 reset = 1'b0;
        hold = 0;
        send(32'h3FC00000, 32'h3FC00000);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        exp_q.delete();
        @(negedge clk);
        #2 reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("abort_not_reported", 32'(seen), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
